// File: rtl/instr_dec_if.sv
// Decoder-facing bundle: instruction handshake in, datapath strobes/data out.
// master = fetch/datapath side, slave = decoder.
interface instr_dec_if #(
    parameter int NBDATA = 32,
    parameter int NBOPCO = 6,
    parameter int NBOPER = 9,
    parameter int MDATAW = 8,
    parameter int SDEPTH = 16
);
    localparam int SPW = $clog2(SDEPTH + 1);

    logic              instr_valid;
    logic              instr_ready;
    logic [NBOPCO-1:0] opcode;
    logic [NBOPER-1:0] operand;
    logic              dsp_push;
    logic              dsp_pop;
    logic              mem_wr;
    logic [MDATAW-1:0] mem_addr;
    logic [NBDATA-1:0] mem_data_in;
    logic [NBDATA-1:0] io_in;
    logic              io_in_valid;
    logic [3:0]        ula_op;
    logic [NBDATA-1:0] ula_data;
    logic              req_in;
    logic              out_en;
    logic              srf;
    logic              busy;
    logic              stk_ovf;
    logic              stk_unf;
    logic              illegal;
    logic [SPW-1:0]    sp_cnt;

    modport slave (
        input  instr_valid, opcode, operand, mem_data_in, io_in, io_in_valid,
        output instr_ready, dsp_push, dsp_pop, mem_wr, mem_addr, ula_op, ula_data,
               req_in, out_en, srf, busy, stk_ovf, stk_unf, illegal, sp_cnt
    );

    modport master (
        output instr_valid, opcode, operand, mem_data_in, io_in, io_in_valid,
        input  instr_ready, dsp_push, dsp_pop, mem_wr, mem_addr, ula_op, ula_data,
               req_in, out_en, srf, busy, stk_ovf, stk_unf, illegal, sp_cnt
    );
endinterface

// File: rtl/instr_dec_pl.sv
// Handshaked instruction decoder: EXEC strobes one cycle after accept (+MLTLAT/DIVLAT, or until io_in_valid for IN).
// instr_ready is a pure state decode, low while waiting on the ULA or input port.
module instr_dec_pl #(
    parameter int NBDATA = 32,
    parameter int NBOPCO = 6,
    parameter int NBOPER = 9,
    parameter int MDATAW = 8,
    parameter int SDEPTH = 16,
    parameter int MLTLAT = 2,
    parameter int DIVLAT = 4
) (
    input logic        clk,
    input logic        rst,
    instr_dec_if.slave bus
);
    localparam int SPW    = $clog2(SDEPTH + 1);
    localparam int MAXLAT = (MLTLAT > DIVLAT) ? MLTLAT : DIVLAT;
    localparam int CW     = $clog2(MAXLAT + 1);

    typedef enum logic [1:0] {IDLE, EXEC, WAIT_ALU, WAIT_IO} state_t;
    typedef enum logic [1:0] {C_ONE, C_MLT, C_DIV, C_IN} cls_t;

    typedef struct packed {
        logic [3:0] ula;
        logic       push;
        logic       pop;
        logic       wr;
        logic       rin;
        logic       oen;
        logic       srf;
        logic       bad;
        cls_t       cls;
    } dec_t;

    function automatic dec_t decode(input logic [NBOPCO-1:0] op);
        dec_t d;
        d = '0;
        case (int'(op))
            0:      d.ula = 4'd1;
            1:      begin d.ula = 4'd1; d.push = 1'b1; d.wr = 1'b1; end
            2:      d.wr = 1'b1;
            3:      begin d.ula = 4'd1; d.wr = 1'b1; d.pop = 1'b1; end
            4:      begin d.wr = 1'b1; d.push = 1'b1; end
            5, 6, 7, 8: d.ula = 4'd0;
            9:      begin d.srf = 1'b1; d.pop = 1'b1; end
            10:     begin d.ula = 4'd1; d.rin = 1'b1; d.pop = 1'b1; d.cls = C_IN; end
            11:     begin d.oen = 1'b1; d.pop = 1'b1; end
            12:     d.ula = 4'd5;
            14, 15: begin d.ula = 4'd2;  d.pop = op[0]; end
            16, 17: begin d.ula = 4'd3;  d.pop = op[0]; d.cls = C_MLT; end
            18, 19: begin d.ula = 4'd4;  d.pop = op[0]; d.cls = C_DIV; end
            24, 25: begin d.ula = 4'd9;  d.pop = op[0]; end
            28, 29: begin d.ula = 4'd11; d.pop = op[0]; end
            36:     d.ula = 4'd8;
            38, 39: begin d.ula = 4'd7;  d.pop = op[0]; end
            40, 41: begin d.ula = 4'd10; d.pop = op[0]; end
            42, 43: begin d.ula = 4'd6;  d.pop = op[0]; end
            default: d.bad = 1'b1;
        endcase
        return d;
    endfunction

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    dec_t              dec_q, dec_in;
    logic [MDATAW-1:0] addr_q;
    logic [NBDATA-1:0] cap_q;
    logic [SPW-1:0]    sp_q;
    logic              ovf_q, unf_q, ill_q;
    logic              rdy, accept, exec, push_ok, pop_ok, full, empty;

    assign rdy     = (state_q == IDLE) || (state_q == EXEC);
    assign accept  = bus.instr_valid && rdy;
    assign dec_in  = decode(bus.opcode);
    assign exec    = (state_q == EXEC);
    assign full    = (sp_q == SPW'(SDEPTH));
    assign empty   = (sp_q == '0);
    assign push_ok = exec && dec_q.push && !full;
    assign pop_ok  = exec && dec_q.pop && !empty;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, EXEC: begin
                if (accept) begin
                    case (dec_in.cls)
                        C_MLT:   begin state_d = WAIT_ALU; cnt_d = CW'(MLTLAT - 1); end
                        C_DIV:   begin state_d = WAIT_ALU; cnt_d = CW'(DIVLAT - 1); end
                        C_IN:    state_d = WAIT_IO;
                        default: state_d = EXEC;
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_ALU: begin
                if (cnt_q == '0) state_d = EXEC;
                else             cnt_d   = cnt_q - 1'b1;
            end
            WAIT_IO: if (bus.io_in_valid) state_d = EXEC;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dec_q   <= '0;
            addr_q  <= '0;
            cap_q   <= '0;
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                dec_q  <= dec_in;
                addr_q <= bus.operand[MDATAW-1:0];
                if (dec_in.bad) ill_q <= 1'b1;
            end
            if (state_q == WAIT_IO && bus.io_in_valid) cap_q <= bus.io_in;
            // push and pop never belong to the same instruction
            if (push_ok)     sp_q <= sp_q + 1'b1;
            else if (pop_ok) sp_q <= sp_q - 1'b1;
            if (exec && dec_q.push && full)  ovf_q <= 1'b1;
            if (exec && dec_q.pop  && empty) unf_q <= 1'b1;
        end
    end

    assign bus.instr_ready = rdy;
    assign bus.busy        = (state_q != IDLE);
    assign bus.dsp_push    = push_ok;
    assign bus.dsp_pop     = pop_ok;
    assign bus.mem_wr      = exec && dec_q.wr;
    assign bus.req_in      = exec && dec_q.rin;
    assign bus.out_en      = exec && dec_q.oen;
    assign bus.srf         = exec && dec_q.srf;
    assign bus.mem_addr    = addr_q;
    assign bus.ula_op      = dec_q.ula;
    assign bus.ula_data    = (exec && dec_q.rin) ? cap_q : bus.mem_data_in;
    assign bus.stk_ovf     = ovf_q;
    assign bus.stk_unf     = unf_q;
    assign bus.illegal     = ill_q;
    assign bus.sp_cnt      = sp_q;
endmodule

// File: doc/instr_dec_pl.md
# instr_dec_pl

Parametrised, handshaked successor to the processor's single-cycle instruction decoder. It sits between instruction fetch and the ULA/data-memory/data-stack datapath. It accepts one instruction per valid/ready handshake and stalls for multi-cycle ULA operations (MLT/DIV) and for IN until input data is present. It tracks data-stack occupancy, suppressing and flagging overflow/underflow, and flags illegal opcodes deterministically instead of driving X.

## Interface
- NBDATA, 32, data width
- NBOPCO, 6, opcode width
- NBOPER, 9, operand width
- MDATAW, 8, data-memory address width (≤ NBOPER)
- SDEPTH, 16, data-stack depth tracked (≥2)
- MLTLAT, 2, extra stall cycles for MLT/SMLT (≥1)
- DIVLAT, 4, extra stall cycles for DIV/SDIV (≥1)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset (sampled on clk; asserted when 0)
- instr_valid  in  1  opcode/operand valid
- instr_ready  out  1  decoder can accept
- opcode  in  NBOPCO  instruction opcode
- operand  in  NBOPER  instruction operand
- dsp_push, dsp_pop  out  1 each  data-stack strobes
- mem_wr  out  1  data-memory write strobe
- mem_addr  out  MDATAW  registered operand[MDATAW-1:0]
- mem_data_in  in  NBDATA  memory read data
- io_in  in  NBDATA  input-port data
- io_in_valid  in  1  io_in holds valid data
- ula_op  out  4  ULA operation code
- ula_data  out  NBDATA  captured io_in when req_in=1, else mem_data_in
- req_in, out_en, srf  out  1 each  IN / OUT / set-register-file strobes
- busy  out  1  state ≠ IDLE
- stk_ovf, stk_unf, illegal  out  1 each  sticky error flags
- sp_cnt  out  $clog2(SDEPTH+1)  current stack occupancy

## Operation
- Opcode map (ula_op; strobes):
  - LOAD 0 (1)
  - PLD 1 (1; push, wr)
  - SET 2 (0; wr)
  - SETP 3 (1; wr, pop)
  - PUSH 4 (0; wr, push)
  - JZ 5, JMP 6, CALL 7, RETURN 8 (0; none)
  - SRF 9 (0; srf, pop)
  - IN 10 (1; req_in, pop)
  - OUT 11 (0; out_en, pop)
  - NEG 12 (5)
  - ADD/SADD 14/15 (2)
  - MLT/SMLT 16/17 (3)
  - DIV/SDIV 18/19 (4)
  - LAND/SLAND 24/25 (9)
  - LOR/SLOR 28/29 (11)
  - LINV 36 (8)
  - EQU/SEQU 38/39 (7)
  - GRE/SGRE 40/41 (10)
  - LES/SLES 42/43 (6)
  - The S-variant (odd code of each pair, 15–43) additionally pops.
- Any other opcode is illegal:
  - ula_op=0, no strobes
  - sets illegal; completes as a normal single-cycle instruction.
- FSM states: IDLE, EXEC, WAIT_ALU, WAIT_IO.
  - Accept = instr_valid && instr_ready. On accept, opcode, operand, ula_op and mem_addr are registered.
  - IDLE/EXEC on accept: MLT/SMLT → WAIT_ALU (cnt=MLTLAT-1); DIV/SDIV → WAIT_ALU (cnt=DIVLAT-1); IN → WAIT_IO; otherwise → EXEC.
  - IDLE/EXEC with no accept → IDLE.
  - WAIT_ALU: cnt decrements; cnt=0 → EXEC.
  - WAIT_IO: io_in_valid=1 → capture io_in, go to EXEC. Waits indefinitely otherwise.
  - instr_ready = 1 in IDLE and EXEC only.
- Strobes (dsp_push, dsp_pop, mem_wr, req_in, out_en, srf) are high only in the EXEC cycle of their instruction, for exactly one cycle.
- ula_op and mem_addr hold from accept+1 until the next accept.
- Stack tracking:
  - push with sp_cnt=SDEPTH → dsp_push suppressed, stk_ovf set, sp_cnt unchanged.
  - pop with sp_cnt=0 → dsp_pop suppressed, stk_unf set.
  - Otherwise sp_cnt ±1 in the EXEC cycle.
  - Other strobes of the same instruction still fire.
- Sticky flags stk_ovf, stk_unf and illegal clear only on reset.

## Timing
- Reset (rst=0 at a clk edge): state=IDLE.
  - All strobes, ula_op, mem_addr, sp_cnt, flags and the capture register are 0.
  - instr_ready=1 in the cycle after reset releases.
- Reset mid-WAIT_ALU/WAIT_IO: abort; the instruction is discarded and no strobes fire.
- Single-cycle op accepted at edge N: EXEC during cycle N+1 (strobes high), with back-to-back accept allowed in that same cycle. Throughput is 1 instruction/cycle.
- MLT accepted at N: WAIT_ALU for MLTLAT cycles, then EXEC; strobes at cycle N+1+MLTLAT. DIV is likewise with DIVLAT.
- IN: EXEC in the cycle after the edge at which io_in_valid=1 is sampled in WAIT_IO. ula_data equals the captured io_in during that EXEC.
- busy and instr_ready are registered-state decodes; no combinational path from instr_valid to instr_ready.

## Test plan
- Reset, then PUSH ×3, SADD → push strobes at cycles 1–3 after each accept, sp_cnt 3→2, ula_op=2 held, dsp_pop in SADD's EXEC only.
- SDEPTH=4: PUSH ×5 → fifth push has no dsp_push, mem_wr=1, stk_ovf=1, sp_cnt=4. Then POP from 0 (OUT after reset) → stk_unf=1, out_en=1, dsp_pop=0.
- DIV (DIVLAT=4) with instr_valid held high → instr_ready low 4 cycles, ula_op=4; the next ADD is accepted in DIV's EXEC cycle.
- IN with io_in_valid low 5 cycles, then io_in=32'hDEADBEEF → busy 6 cycles; EXEC shows req_in=1, ula_data=32'hDEADBEEF, dsp_pop=1.
- Opcode 13 and 63 → illegal=1, ula_op=0, no strobes, next LOAD (operand 9'h1A5) gives mem_addr=8'hA5, ula_op=1.
- rst=0 asserted during WAIT_ALU → next cycle all outputs 0, state IDLE, no EXEC strobe ever emitted.
